// File: rtl/regfile_arbiter.sv
// Arbiter for the shared single-port 128x8 register file: requester 0 (SPI) has
// priority, the others share round-robin, and starvation counters let them pre-empt SPI.
module regfile_arbiter #(
    parameter int N_REQ        = 3,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     req_we,
    input  logic [7*N_REQ-1:0]   req_addr,
    input  logic [8*N_REQ-1:0]   req_wdata,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     rvalid,
    output logic [7:0]           rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [6:0]           mem_addr,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata,
    output logic                 busy
);

    localparam int               PW    = $clog2(N_REQ);
    localparam logic [7:0]       LIMIT = 8'(STARVE_LIMIT);
    localparam logic [N_REQ-1:0] ONE   = N_REQ'(1);

    // Handshake: req (with we/addr/wdata) is held until gnt; gnt is a one-cycle
    // pulse, and a read grant is followed by exactly one rvalid pulse the next cycle.
    logic [N_REQ-1:0] elig;
    logic             win_valid;
    logic [PW-1:0]    win_idx;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    rr_idx;
    int               rr_j;
    logic [7:0]       cnt [1:N_REQ-1];

    // A requester currently seeing its grant cannot be granted again this cycle.
    assign elig  = req & ~gnt;
    assign rdata = mem_rdata;
    assign busy  = ~reset & ((|elig) | mem_en | (|rvalid));

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        rr_j      = 0;
        rr_idx    = '0;
        // Descending scan so the lowest-index starved requester ends up the winner.
        for (int i = N_REQ - 1; i >= 1; i--) begin
            if (elig[i] && cnt[i] == LIMIT) begin
                win_valid = 1'b1;
                win_idx   = PW'(i);
            end
        end
        if (!win_valid && elig[0]) begin
            win_valid = 1'b1;
            win_idx   = '0;
        end
        if (!win_valid) begin
            for (int k = N_REQ - 2; k >= 0; k--) begin
                rr_j = int'(ptr) + k;
                if (rr_j >= N_REQ) rr_j = rr_j - (N_REQ - 1);
                rr_idx = PW'(rr_j);
                if (elig[rr_idx]) begin
                    win_valid = 1'b1;
                    win_idx   = rr_idx;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt       <= '0;
            rvalid    <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ptr       <= PW'(1);
            for (int i = 1; i < N_REQ; i++) cnt[i] <= '0;
        end else begin
            rvalid <= (mem_en && !mem_we) ? gnt : '0;
            if (win_valid) begin
                gnt       <= ONE << win_idx;
                mem_en    <= 1'b1;
                mem_we    <= req_we[win_idx];
                mem_addr  <= req_addr[7*int'(win_idx) +: 7];
                mem_wdata <= req_wdata[8*int'(win_idx) +: 8];
                if (win_idx != '0)
                    ptr <= (win_idx == PW'(N_REQ - 1)) ? PW'(1) : win_idx + PW'(1);
            end else begin
                gnt    <= '0;
                mem_en <= 1'b0;
                mem_we <= 1'b0;
            end
            for (int i = 1; i < N_REQ; i++) begin
                if (!req[i] || (win_valid && win_idx == PW'(i)))
                    cnt[i] <= '0;
                else if (elig[i] && cnt[i] != LIMIT)
                    cnt[i] <= cnt[i] + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed scenarios plus random traffic checked every
// cycle against a rule-level model of arbitration and a shadow copy of the register file.
module tb_regfile_arbiter;

    localparam int N  = 4;
    localparam int SL = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req, req_we;
    logic [7*N-1:0] req_addr;
    logic [8*N-1:0] req_wdata;
    logic [N-1:0]   gnt, rvalid;
    logic [7:0]     rdata, mem_wdata, mem_rdata;
    logic           mem_en, mem_we, busy;
    logic [6:0]     mem_addr;

    regfile_arbiter #(.N_REQ(N), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Register file attached to the arbiter, plus the shadow copy the model uses.
    logic [7:0] ram    [128];
    logic [7:0] shadow [128];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the arbitration rules.
    logic [N-1:0] m_gnt, m_rvalid;
    logic         m_en, m_we;
    logic [6:0]   m_addr;
    logic [7:0]   m_wdata;
    int           m_cnt [N];
    int           m_ptr;
    logic [7:0]   exp_q [$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_gnt = '0; m_rvalid = '0; m_en = 1'b0; m_we = 1'b0;
            m_addr = '0; m_wdata = '0; m_ptr = 1;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            exp_q.delete();
        end else begin
            logic [N-1:0] el;
            int w;
            el = req & ~m_gnt;
            m_rvalid = '0;
            if (m_en) begin
                if (m_we) shadow[m_addr] = m_wdata;
                else begin
                    exp_q.push_back(shadow[m_addr]);
                    m_rvalid = m_gnt;
                end
            end
            w = -1;
            for (int i = 1; i < N; i++)
                if (w < 0 && el[i] && m_cnt[i] == SL) w = i;
            if (w < 0 && el[0]) w = 0;
            for (int k = 0; k < N - 1; k++) begin
                int j;
                j = ((m_ptr - 1 + k) % (N - 1)) + 1;
                if (w < 0 && el[j]) w = j;
            end
            for (int i = 1; i < N; i++) begin
                if (!req[i] || w == i) m_cnt[i] = 0;
                else if (el[i] && m_cnt[i] < SL) m_cnt[i] = m_cnt[i] + 1;
            end
            if (w >= 0) begin
                m_gnt   = '0;
                m_gnt[w] = 1'b1;
                m_en    = 1'b1;
                m_we    = req_we[w];
                m_addr  = req_addr[7*w +: 7];
                m_wdata = req_wdata[8*w +: 8];
                if (w >= 1) m_ptr = (w == N - 1) ? 1 : w + 1;
            end else begin
                m_gnt = '0;
                m_en  = 1'b0;
                m_we  = 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("gnt", 32'(gnt), 32'(m_gnt));
            check("rvalid", 32'(rvalid), 32'(m_rvalid));
            check("mem_en", 32'(mem_en), 32'(m_en));
            check("mem_we", 32'(mem_we), 32'(m_we));
            check("mem_addr", 32'(mem_addr), 32'(m_addr));
            check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            check("busy", 32'(busy), 32'((|(req & ~m_gnt)) | m_en | (|m_rvalid)));
            if (m_rvalid != '0) begin
                if (exp_q.size() == 0) check("rdata_queue", 32'(1), 32'(0));
                else check("rdata", 32'(rdata), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic set_req(input int i, input logic we, input logic [6:0] a, input logic [7:0] d);
        req[i] = 1'b1;
        req_we[i] = we;
        req_addr[7*i +: 7] = a;
        req_wdata[8*i +: 8] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    logic [N-1:0] rr_exp [4];
    logic [N-1:0] st_exp [6];

    initial begin
        reset = 1'b1;
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        for (int a = 0; a < 128; a++) begin
            ram[a] = 8'($urandom_range(0, 255));
            shadow[a] = ram[a];
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_gnt", 32'(gnt), 32'(0));
        check("reset_mem_en", 32'(mem_en), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        reset = 1'b0;
        chk_en = 1'b1;
        step();

        // Single read
        ram[5] = 8'hA7; shadow[5] = 8'hA7;
        set_req(1, 1'b0, 7'h05, 8'h00);
        step();
        req[1] = 1'b0;
        @(negedge clk);
        check("read_gnt", 32'(gnt), 32'(4'b0010));
        check("read_addr", 32'(mem_addr), 32'h05);
        check("read_we", 32'(mem_we), 32'(0));
        step();
        @(negedge clk);
        check("read_rvalid", 32'(rvalid), 32'(4'b0010));
        check("read_rdata", 32'(rdata), 32'hA7);
        repeat (2) step();

        // Priority: write from 0 precedes read from 1 to the same address
        set_req(0, 1'b1, 7'h40, 8'h3C);
        set_req(1, 1'b0, 7'h40, 8'h00);
        step();
        req[0] = 1'b0;
        @(negedge clk);
        check("prio_gnt0", 32'(gnt), 32'(4'b0001));
        check("prio_wdata", 32'(mem_wdata), 32'h3C);
        step();
        req[1] = 1'b0;
        @(negedge clk);
        check("prio_gnt1", 32'(gnt), 32'(4'b0010));
        step();
        @(negedge clk);
        check("prio_rvalid", 32'(rvalid), 32'(4'b0010));
        check("prio_rdata", 32'(rdata), 32'h3C);

        // Round-robin between 1 and 2 from a fresh pointer
        do_reset();
        rr_exp = '{4'b0010, 4'b0100, 4'b0010, 4'b0100};
        set_req(1, 1'b1, 7'h10, 8'h11);
        set_req(2, 1'b1, 7'h11, 8'h22);
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk);
            check("rr_order", 32'(gnt), 32'(rr_exp[k]));
        end
        req = '0;

        // Starvation: all requesters held, limit reached by 2 then 3, then 0 resumes
        do_reset();
        st_exp = '{4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 7'(8'h20 + i), 8'(i));
        for (int k = 0; k < 6; k++) begin
            step();
            @(negedge clk);
            check("starve_order", 32'(gnt), 32'(st_exp[k]));
        end
        req = '0;

        // Reset while a read grant is in flight
        do_reset();
        set_req(1, 1'b0, 7'h09, 8'h00);
        step();
        req[1] = 1'b0;
        @(negedge clk);
        check("rst_read_gnt", 32'(gnt), 32'(4'b0010));
        #2 reset = 1'b1;
        #1;
        check("rst_outs", 32'({gnt, rvalid, mem_en, mem_we, busy}), 32'(0));
        check("rst_addr_data", 32'({mem_addr, mem_wdata}), 32'(0));
        step();
        check("rst_no_rvalid", 32'(rvalid), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        step();
        set_req(2, 1'b0, 7'h0A, 8'h00);
        step();
        req[2] = 1'b0;
        @(negedge clk);
        check("rst_fresh_gnt", 32'(gnt), 32'(4'b0100));

        // Idle
        repeat (3) step();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle", 32'({mem_en, gnt, rvalid, busy}), 32'(0));
            step();
        end

        // Random traffic; the driver keeps the req-until-gnt protocol using the model
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] || m_gnt[i]) begin
                    if ($urandom_range(0, 2) == 0)
                        set_req(i, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)),
                                8'($urandom_range(0, 255)));
                    else
                        req[i] = 1'b0;
                end
            end
            step();
        end
        req = '0;
        repeat (5) step();
        check("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
